// File: rtl/riscv_pkg.sv
// Shared constants and types for the 5-stage RISC-V core's pipeline control blocks.
package riscv_pkg;
  localparam int REG_AW          = 5;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, holds at all-ones, clears only on reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush, load-use stall.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int  CNT_W       = 32,
  parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int WC_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic [REG_AW-1:0]   id_ex_rd,
  input  logic                id_ex_memread,
  input  logic                ex_branch_taken,
  input  logic                ex_mem_memread,
  input  logic                ex_mem_memwrite,
  input  logic                dmem_ready,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                id_ex_write,
  output logic                ex_mem_write,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                mem_wb_bubble,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count,
  output hazard_state_t       dbg_state,
  output logic [WC_W-1:0]     dbg_wait_cnt
);
  // Handshake: none -- every control output is a same-cycle combinational
  // function of inputs and state; the pipeline registers obey them on the next edge.

  hazard_state_t   state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  // Cleared by reset, set by the first edge afterwards; outputs stay at reset values until then.
  logic            active_q;

  logic mem_access, freeze, load_use;

  assign mem_access = ex_mem_memread | ex_mem_memwrite;
  assign freeze     = active_q & mem_access & ~dmem_ready;
  assign load_use   = id_ex_memread & (id_ex_rd != '0) &
                      ((id_ex_rd == id_rs1) | (id_ex_rd == id_rs2));

  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    id_ex_write   = 1'b0;
    ex_mem_write  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (active_q) begin
      if (freeze) begin
        mem_wb_bubble = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (freeze) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!freeze) state_d = RUN;
        if (wait_cnt_q != WC_W'(TIMEOUT_CYC)) wait_cnt_d = wait_cnt_q + 1'b1;
        if (freeze && (wait_cnt_q == WC_W'(TIMEOUT_CYC - 1))) timeout_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      active_q   <= 1'b1;
    end
  end

  assign mem_timeout  = timeout_q;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;

`ifdef HAZARD_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active_q & ~pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_id_flush),
    .count (flush_count)
  );
`else
  assign stall_count = {CNT_W{1'b0}};
  assign flush_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (TIMEOUT_CYC=4); works with or without HAZARD_PERF_EN.
module tb_hazard_unit;
  import riscv_pkg::*;

  localparam int TO    = 4;
  localparam int CW    = 32;
  localparam int WCW   = $clog2(TO + 1);
`ifdef HAZARD_PERF_EN
  localparam int PERF  = 1;
`else
  localparam int PERF  = 0;
`endif

  // ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] C_RST    = 7'b0000_000;
  localparam logic [6:0] C_IDLE   = 7'b1111_000;
  localparam logic [6:0] C_LDUSE  = 7'b0011_010;
  localparam logic [6:0] C_BRANCH = 7'b1111_110;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic id_ex_memread, ex_branch_taken, ex_mem_memread, ex_mem_memwrite, dmem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;
  hazard_state_t dbg_state;
  logic [WCW-1:0] dbg_wait_cnt;
  logic [6:0] ctrl;

  int tests = 0;
  int fails = 0;
  logic [CW-1:0] s0, f0;

  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_flush, mem_wb_bubble};

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_memread   (id_ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .ex_mem_memread  (ex_mem_memread),
    .ex_mem_memwrite (ex_mem_memwrite),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .dbg_state       (dbg_state),
    .dbg_wait_cnt    (dbg_wait_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic ld, input logic br, input logic mrd, input logic mwr,
                       input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_ex_rd = rd; id_ex_memread = ld;
    ex_branch_taken = br; ex_mem_memread = mrd; ex_mem_memwrite = mwr; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) tick();
    check("rst_ctrl",    32'(ctrl), 32'(C_RST));
    check("rst_state",   32'(dbg_state), 32'(RUN));
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check("rst_stall",   stall_count, 32'd0);
    check("rst_flush",   flush_count, 32'd0);

    @(negedge clk); reset = 1'b0;
    tick();
    @(negedge clk); #1;
    check("idle_ctrl", 32'(ctrl), 32'(C_IDLE));
    s0 = stall_count; f0 = flush_count;

    // Load-use on rs2: one stall cycle, then the load has left EX.
    @(negedge clk);
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    check("lduse_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    check("lduse_stall", stall_count, s0 + 32'(PERF));
    @(negedge clk); idle(); #1;
    check("lduse_release", 32'(ctrl), 32'(C_IDLE));
    tick();
    check("lduse_stall_hold", stall_count, s0 + 32'(PERF));

    // Load-use on rs1 as well.
    @(negedge clk);
    drive(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    check("lduse_rs1_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    check("lduse_rs1_stall", stall_count, s0 + 32'(2 * PERF));

    // x0 destination never stalls.
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    check("rd0_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    check("rd0_stall", stall_count, s0 + 32'(2 * PERF));

    // Branch beats load-use.
    @(negedge clk);
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    check("branch_ctrl", 32'(ctrl), 32'(C_BRANCH));
    tick();
    check("branch_flush", flush_count, f0 + 32'(PERF));
    check("branch_stall", stall_count, s0 + 32'(2 * PERF));

    // Ready in the first access cycle: no freeze, no state change.
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); #1;
    check("ready_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    check("ready_state", 32'(dbg_state), 32'(RUN));

    // Three wait cycles; freeze also overrides a pending branch + load-use.
    @(negedge clk);
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    check("wait1_ctrl", 32'(ctrl), 32'(C_FREEZE));
    check("wait1_state", 32'(dbg_state), 32'(RUN));
    tick();
    check("wait1_next", 32'(dbg_state), 32'(MEM_WAIT));
    check("wait1_cnt", 32'(dbg_wait_cnt), 32'd0);
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    check("wait2_ctrl", 32'(ctrl), 32'(C_FREEZE));
    tick();
    @(negedge clk); #1;
    check("wait3_ctrl", 32'(ctrl), 32'(C_FREEZE));
    check("wait3_state", 32'(dbg_state), 32'(MEM_WAIT));
    tick();
    check("wait3_cnt", 32'(dbg_wait_cnt), 32'd2);
    @(negedge clk); dmem_ready = 1'b1; #1;
    check("wait_done_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    check("wait_done_state", 32'(dbg_state), 32'(RUN));
    check("wait_stall", stall_count, s0 + 32'(5 * PERF));
    check("wait_no_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk); idle();

    // Timeout after the 5th frozen edge; sticky and does not release freeze.
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    check("to_before", 32'(mem_timeout), 32'd0);
    check("to_cnt3", 32'(dbg_wait_cnt), 32'd3);
    tick();
    check("to_set", 32'(mem_timeout), 32'd1);
    check("to_still_frozen", 32'(ctrl), 32'(C_FREEZE));
    tick();
    check("to_cnt_sat", 32'(dbg_wait_cnt), 32'(TO));
    @(negedge clk); dmem_ready = 1'b1;
    repeat (2) tick();
    check("to_sticky", 32'(mem_timeout), 32'd1);
    check("to_state_run", 32'(dbg_state), 32'(RUN));
    check("to_stall", stall_count, s0 + 32'(11 * PERF));
    @(negedge clk); idle();

    // Reset asserted between edges while waiting with wait_cnt=2.
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("mid_state", 32'(dbg_state), 32'(MEM_WAIT));
    check("mid_cnt", 32'(dbg_wait_cnt), 32'd2);
    @(negedge clk); reset = 1'b1; #1;
    check("mid_rst_state", 32'(dbg_state), 32'(RUN));
    check("mid_rst_cnt", 32'(dbg_wait_cnt), 32'd0);
    check("mid_rst_timeout", 32'(mem_timeout), 32'd0);
    check("mid_rst_ctrl", 32'(ctrl), 32'(C_RST));
    check("mid_rst_stall", stall_count, 32'd0);
    check("mid_rst_flush", flush_count, 32'd0);
    idle();
    tick();
    @(negedge clk); reset = 1'b0; #1;
    check("post_rst_hold", 32'(ctrl), 32'(C_RST));
    tick();
    @(negedge clk); #1;
    check("post_rst_idle", 32'(ctrl), 32'(C_IDLE));
    s0 = stall_count;
    drive(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    check("post_rst_lduse", 32'(ctrl), 32'(C_LDUSE));
    tick();
    check("post_rst_stall", stall_count, s0 + 32'(PERF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. It resolves the hazards that operand forwarding cannot cover: load-use stalls, taken-branch flushes and data-memory wait states. It produces the pipeline-register write enables and flush strobes, and sits beside the forwarding logic in the ID/EX boundary control path. Optional saturating performance counters report stall and flush activity.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `TIMEOUT_CYC`, default 255: maximum number of consecutive data-memory wait cycles before `mem_timeout` is raised.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `id_ex_memread`  in  1  instruction in EX is a load.
- `ex_branch_taken`  in  1  branch or jump in EX resolved as taken.
- `ex_mem_memread`, `ex_mem_memwrite`  in  1 each  MEM stage is accessing data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`  out  1 each  pipeline register enables.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a NOP bubble into the named register.
- `mem_wb_bubble`  out  1  insert a bubble into MEM/WB.
- `mem_timeout`  out  1  sticky error flag.
- `stall_count`, `flush_count`  out  `CNT_W` each  performance counters.

## Operation
- `mem_access = ex_mem_memread | ex_mem_memwrite`.
- `freeze = mem_access & ~dmem_ready`.
- `load_use = id_ex_memread & (id_ex_rd != 0) & (id_ex_rd == id_rs1 | id_ex_rd == id_rs2)`.
- Priority order: freeze, then branch flush, then load-use.
  - **Freeze:** all four write enables are 0 and `mem_wb_bubble=1`. Flush strobes are 0. Branch and load-use detection are ignored and re-evaluated once the pipeline moves.
  - **Branch flush** (`ex_branch_taken`, no freeze): `if_id_flush=1` and `id_ex_flush=1`. All write enables are 1. Load-use is ignored because the ID instruction is squashed.
  - **Load-use** (no freeze, no branch): `pc_write=0`, `if_id_write=0`, `id_ex_flush=1`. `id_ex_write` and `ex_mem_write` are 1. This lasts exactly one cycle, because the load then leaves EX.
  - **Otherwise:** all write enables are 1, flushes are 0 and `mem_wb_bubble=0`.
- The FSM has two states, RUN and MEM_WAIT.
  - RUN goes to MEM_WAIT on an edge where `freeze=1`.
  - MEM_WAIT goes to RUN on an edge where `freeze=0`.
  - The wait counter `wait_cnt` clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT, saturating at `TIMEOUT_CYC`.
- `mem_timeout` sets on the edge where the FSM is in MEM_WAIT, `wait_cnt == TIMEOUT_CYC-1` and `freeze=1`. It stays set until reset. The timeout does not release the freeze.
- While `reset=1`: all write enables, flushes and `mem_wb_bubble` are 0. State is RUN, `wait_cnt=0`, `mem_timeout=0`, counters are 0.

## Timing
- Every control output is combinational from the current inputs and state, so it acts in the same cycle as the hazard.
- FSM, `wait_cnt`, `mem_timeout` and the counters update on the next rising edge.
- `dmem_ready=1` in the first access cycle gives no freeze and no state change.
- A single-cycle `freeze` pulse enters MEM_WAIT for one cycle and returns to RUN on the next edge.
- Reset asserted mid-wait returns the FSM to RUN immediately (asynchronous). Outputs hold the reset values until the first edge after deassertion.

## Configuration
- Macro `HAZARD_PERF_EN`.
- **Defined:** `stall_count` increments on every cycle with `pc_write=0` and reset deasserted. `flush_count` increments on every cycle with `if_id_flush=1`. Both saturate at all-ones and clear only on reset.
- **Undefined:** no counter registers exist and both outputs are tied to 0.

## Structure
- Package `riscv_pkg`:
  - register-address width constant (5);
  - `hazard_state_t` enum (RUN, MEM_WAIT);
  - default `TIMEOUT_CYC`.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `count`). It is instantiated twice under `HAZARD_PERF_EN`.

## Test plan
- **Load-use:** `id_ex_memread=1`, `id_ex_rd=5`, `id_rs2=5`, `dmem_ready=1` → for one cycle `pc_write=0`, `if_id_write=0`, `id_ex_flush=1`, `id_ex_write=1`; `stall_count` goes 0 → 1. Repeat with `id_ex_rd=0` → no stall.
- **Branch beats load-use:** load-use condition plus `ex_branch_taken=1` → `if_id_flush=1`, `id_ex_flush=1`, `pc_write=1`; `flush_count` goes to 1 and `stall_count` is unchanged.
- **Memory wait:** `ex_mem_memread=1`, `dmem_ready=0` for 3 cycles, then 1 → all enables 0 and `mem_wb_bubble=1` for 3 cycles. The FSM is in MEM_WAIT for 3 cycles, then RUN; `stall_count=3`.
- **Timeout:** `TIMEOUT_CYC=4`, `dmem_ready` held at 0 → `mem_timeout` rises after the 5th frozen cycle's edge and stays 1 after `dmem_ready=1`, until reset.
- **Reset mid-wait:** in MEM_WAIT with `wait_cnt=2`, assert `reset` between edges → state RUN, counters 0 and `mem_timeout=0` immediately, with all enables 0.
- **Build without `HAZARD_PERF_EN`:** rerun the first scenario → same control outputs, and `stall_count`/`flush_count` stay at 0.
